// File: rtl/arm_target_selector_if.sv
// Bundle between the mode FSM / position sources and the arm target selector.
// Carries the mode, the three qualified position sources and the servo target outputs.
interface arm_target_selector_if #(
  parameter int POS_W = 8
);
  // Each *_pos is taken on a cycle where its *_valid is high and that source is
  // selected. There is no ready: sources are never back-pressured, and a valid
  // the selector chooses to ignore is simply lost.
  logic [1:0]       state;
  logic [POS_W-1:0] kb_pos;
  logic             kb_valid;
  logic [POS_W-1:0] us_pos;
  logic             us_valid;
  logic [POS_W-1:0] an_pos;
  logic             an_valid;
  logic [POS_W-1:0] target;
  logic             target_valid;
  logic             settling;
  logic [1:0]       src_active;
  logic [1:0]       fsm_dbg;

  modport master (
    output state, kb_pos, kb_valid, us_pos, us_valid, an_pos, an_valid,
    input  target, target_valid, settling, src_active, fsm_dbg
  );

  modport slave (
    input  state, kb_pos, kb_valid, us_pos, us_valid, an_pos, an_valid,
    output target, target_valid, settling, src_active, fsm_dbg
  );
endinterface

// File: rtl/arm_target_selector.sv
// Chooses the arm position source for the current mode and produces a jump-free servo target.
// Optional feature: define SOURCE_TIMEOUT_EN to park the arm when the selected source goes silent.
module arm_target_selector #(
  parameter int POS_W          = 8,
  parameter int HOME_POS       = 128,
  parameter int BLANK_CYCLES   = 100000,
  parameter int SLEW_DIV       = 10000,
  parameter int MAX_JUMP       = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_target_selector_if.slave bus
);

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int PRE_W   = $clog2(SLEW_DIV + 1);
  localparam logic [POS_W-1:0] HOME = POS_W'(HOME_POS);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SLEW  = 2'd1,
    ST_TRACK = 2'd2
  } fsm_t;

  fsm_t               r_fsm;
  logic [POS_W-1:0]   r_target;
  logic [POS_W-1:0]   r_goal;
  logic [1:0]         r_src_active;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [PRE_W-1:0]   r_pre_cnt;

  fsm_t               w_fsm_nxt;
  logic [POS_W-1:0]   w_target_nxt;
  logic [POS_W-1:0]   w_goal_nxt;
  logic [1:0]         w_src_nxt;
  logic [BLANK_W-1:0] w_blank_nxt;
  logic [PRE_W-1:0]   w_pre_nxt;

  logic               w_mode_change;
  logic               w_sel_valid;
  logic [POS_W-1:0]   w_sel_pos;
  logic [POS_W:0]     w_pos_ext;
  logic [POS_W:0]     w_tgt_ext;
  logic [POS_W:0]     w_diff;
  logic               w_small_jump;
  logic               w_blank_done;
  logic               w_tick;

  assign w_mode_change = (bus.state != r_src_active);

  // Only the source belonging to the applied mode is ever looked at.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_pos   = '0;
    case (r_src_active)
      2'b01: begin w_sel_valid = bus.us_valid; w_sel_pos = bus.us_pos; end
      2'b10: begin w_sel_valid = bus.kb_valid; w_sel_pos = bus.kb_pos; end
      2'b11: begin w_sel_valid = bus.an_valid; w_sel_pos = bus.an_pos; end
      default: ;
    endcase
  end

  // One extra bit keeps the distance exact across the whole unsigned range.
  assign w_pos_ext    = {1'b0, w_sel_pos};
  assign w_tgt_ext    = {1'b0, r_target};
  assign w_diff       = (w_pos_ext >= w_tgt_ext) ? (w_pos_ext - w_tgt_ext)
                                                 : (w_tgt_ext - w_pos_ext);
  assign w_small_jump = (w_diff <= (POS_W+1)'(MAX_JUMP));
  assign w_blank_done = (r_blank_cnt == BLANK_W'(BLANK_CYCLES - 1));
  assign w_tick       = (r_pre_cnt == PRE_W'(SLEW_DIV - 1));

`ifdef SOURCE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_target_nxt = r_target;
    w_goal_nxt   = r_goal;
    w_src_nxt    = r_src_active;
    w_blank_nxt  = r_blank_cnt;
    w_pre_nxt    = r_pre_cnt;
`ifdef SOURCE_TIMEOUT_EN
    w_to_nxt     = r_to_cnt;
`endif

    if (w_mode_change) begin
      // A mode change outranks any valid arriving in the same cycle.
      w_src_nxt   = bus.state;
      w_fsm_nxt   = ST_BLANK;
      w_blank_nxt = '0;
      w_goal_nxt  = r_target;
    end else begin
      case (r_fsm)
        ST_BLANK: begin
          if (w_blank_done) begin
            w_fsm_nxt = ST_SLEW;
            w_pre_nxt = '0;
            if (r_src_active == 2'b00) w_goal_nxt = HOME;
          end else begin
            w_blank_nxt = r_blank_cnt + BLANK_W'(1);
          end
        end
        ST_SLEW: begin
          if (w_sel_valid) w_goal_nxt = w_sel_pos;
          if (w_tick) begin
            w_pre_nxt = '0;
            if (r_target == r_goal)     w_fsm_nxt    = ST_TRACK;
            else if (r_target < r_goal) w_target_nxt = r_target + POS_W'(1);
            else                        w_target_nxt = r_target - POS_W'(1);
          end else begin
            w_pre_nxt = r_pre_cnt + PRE_W'(1);
          end
        end
        ST_TRACK: begin
          if (w_sel_valid) begin
            w_goal_nxt = w_sel_pos;
            if (w_small_jump) begin
              w_target_nxt = w_sel_pos;
            end else begin
              w_fsm_nxt = ST_SLEW;
              w_pre_nxt = '0;
            end
          end
        end
        default: w_fsm_nxt = ST_BLANK;
      endcase
    end

`ifdef SOURCE_TIMEOUT_EN
    // Counter saturates once it fires so a parked arm is not re-parked every period.
    if (w_mode_change || w_sel_valid || (r_src_active == 2'b00) ||
        !((r_fsm == ST_SLEW) || (r_fsm == ST_TRACK))) begin
      w_to_nxt = '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      w_to_nxt = r_to_cnt + TO_W'(1);
      if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        w_goal_nxt = HOME;
        w_fsm_nxt  = ST_SLEW;
        w_pre_nxt  = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm        <= ST_BLANK;
      r_target     <= HOME;
      r_goal       <= HOME;
      r_src_active <= 2'b00;
      r_blank_cnt  <= '0;
      r_pre_cnt    <= '0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_target     <= w_target_nxt;
      r_goal       <= w_goal_nxt;
      r_src_active <= w_src_nxt;
      r_blank_cnt  <= w_blank_nxt;
      r_pre_cnt    <= w_pre_nxt;
    end
  end

`ifdef SOURCE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) r_to_cnt <= '0;
    else       r_to_cnt <= w_to_nxt;
  end
`endif

  assign bus.target       = r_target;
  assign bus.target_valid = (r_fsm != ST_BLANK);
  assign bus.settling     = (r_fsm != ST_TRACK);
  assign bus.src_active   = r_src_active;
  assign bus.fsm_dbg      = r_fsm;

endmodule

// File: tb/tb_arm_target_selector.sv
// Directed bench for arm_target_selector: vector table for TRACK behaviour plus
// hand-written sequences for blanking, slewing, range limits and source silence.
module tb_arm_target_selector;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arm_target_selector_if #(.POS_W(8)) bus ();

  arm_target_selector #(
    .POS_W(8), .HOME_POS(128), .BLANK_CYCLES(8), .SLEW_DIV(4),
    .MAX_JUMP(16), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       kv;
    logic [7:0] kp;
    logic       uv;
    logic [7:0] up;
    logic       av;
    logic [7:0] ap;
    logic [7:0] exp_tgt;
    logic       exp_set;
  } vec_t;

  vec_t vt[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle_sources();
    bus.kb_valid = 1'b0;
    bus.us_valid = 1'b0;
    bus.an_valid = 1'b0;
  endtask

  // Waits for TRACK with a cycle budget; an expired budget is a failed check.
  task automatic wait_track(input string name, input int budget);
    int n;
    n = 0;
    while (bus.settling && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(bus.settling), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    vt[0]  = '{2'd2, 1'b1, 8'd150, 1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b0};
    vt[1]  = '{2'd2, 1'b0, 8'd0,   1'b1, 8'd151, 1'b0, 8'd0,   8'd150, 1'b0};
    vt[2]  = '{2'd2, 1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 8'd149, 8'd150, 1'b0};
    vt[3]  = '{2'd2, 1'b1, 8'd166, 1'b0, 8'd0,   1'b0, 8'd0,   8'd166, 1'b0};
    vt[4]  = '{2'd2, 1'b0, 8'd10,  1'b0, 8'd0,   1'b0, 8'd0,   8'd166, 1'b0};
    vt[5]  = '{2'd2, 1'b1, 8'd150, 1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b0};
    vt[6]  = '{2'd2, 1'b1, 8'd167, 1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b1};
    vt[7]  = '{2'd2, 1'b1, 8'd150, 1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b1};
    vt[8]  = '{2'd2, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b1};
    vt[9]  = '{2'd2, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b1};
    vt[10] = '{2'd2, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b0};
    vt[11] = '{2'd2, 1'b1, 8'd200, 1'b0, 8'd0,   1'b0, 8'd0,   8'd150, 1'b1};

    // Reset and the mode-00 start-up
    reset = 1'b1;
    bus.state = 2'd0;
    bus.kb_pos = '0; bus.us_pos = '0; bus.an_pos = '0;
    idle_sources();
    repeat (3) tick();
    chk("rst_target", int'(bus.target), 128);
    chk("rst_tvalid", int'(bus.target_valid), 0);
    chk("rst_settling", int'(bus.settling), 1);
    chk("rst_src", int'(bus.src_active), 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_blank_tvalid", int'(bus.target_valid), 0);
    end
    tick();
    chk("t1_slew_tvalid", int'(bus.target_valid), 1);
    chk("t1_slew_settling", int'(bus.settling), 1);
    repeat (3) tick();
    chk("t1_pre_tick_settling", int'(bus.settling), 1);
    tick();
    chk("t1_track_settling", int'(bus.settling), 0);
    chk("t1_track_target", int'(bus.target), 128);

    // Keyboard mode: blank, then slew 128 -> 140
    bus.state = 2'd2;
    bus.kb_pos = 8'd140;
    bus.kb_valid = 1'b1;
    tick();
    chk("t2_src", int'(bus.src_active), 2);
    chk("t2_blank_tvalid", int'(bus.target_valid), 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_blank_tvalid", int'(bus.target_valid), 0);
      chk("t2_blank_target", int'(bus.target), 128);
    end
    tick();
    chk("t2_slew_tvalid", int'(bus.target_valid), 1);
    for (int i = 0; i < 48; i++) begin
      tick();
      chk("t2_slew_target", int'(bus.target), 128 + (i + 1) / 4);
      chk("t2_slew_settling", int'(bus.settling), 1);
    end
    repeat (3) tick();
    chk("t2_hold_settling", int'(bus.settling), 1);
    tick();
    chk("t2_track_settling", int'(bus.settling), 0);
    chk("t2_track_target", int'(bus.target), 140);

    // TRACK vectors: direct moves, the MAX_JUMP boundary, foreign sources
    for (int i = 0; i < 12; i++) begin
      bus.state    = vt[i].st;
      bus.kb_valid = vt[i].kv; bus.kb_pos = vt[i].kp;
      bus.us_valid = vt[i].uv; bus.us_pos = vt[i].up;
      bus.an_valid = vt[i].av; bus.an_pos = vt[i].ap;
      tick();
      chk($sformatf("vec%0d_target", i), int'(bus.target), int'(vt[i].exp_tgt));
      chk($sformatf("vec%0d_settling", i), int'(bus.settling), int'(vt[i].exp_set));
    end
    idle_sources();
    bus.kb_valid = 1'b1;
    bus.kb_pos = 8'd200;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("t3_slew_target", int'(bus.target), 150 + (i + 1) / 4);
    end
    repeat (3) tick();
    chk("t3_hold_settling", int'(bus.settling), 1);
    tick();
    chk("t3_track_settling", int'(bus.settling), 0);
    chk("t3_track_target", int'(bus.target), 200);

    // Mode change with simultaneous valids, then a restart mid-blank
    bus.state = 2'd1;
    bus.kb_valid = 1'b1; bus.kb_pos = 8'd10;
    bus.us_valid = 1'b1; bus.us_pos = 8'd10;
    tick();
    chk("t4_src", int'(bus.src_active), 1);
    chk("t4_tvalid", int'(bus.target_valid), 0);
    chk("t4_target", int'(bus.target), 200);
    idle_sources();
    repeat (5) tick();
    chk("t4_blank5_tvalid", int'(bus.target_valid), 0);
    bus.state = 2'd3;
    bus.an_valid = 1'b1; bus.an_pos = 8'd0;
    tick();
    chk("t4_src2", int'(bus.src_active), 3);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) idle_sources();
      tick();
      chk("t4_restart_tvalid", int'(bus.target_valid), 0);
    end
    tick();
    chk("t4_slew_tvalid", int'(bus.target_valid), 1);
    repeat (3) tick();
    chk("t4_hold_settling", int'(bus.settling), 1);
    tick();
    chk("t4_track_settling", int'(bus.settling), 0);
    chk("t4_track_target", int'(bus.target), 200);

    // Analog mode: climb to the top of the range, then slew all the way down
    bus.an_valid = 1'b1;
    bus.an_pos = 8'd216; tick(); chk("t5_216", int'(bus.target), 216);
    bus.an_pos = 8'd232; tick(); chk("t5_232", int'(bus.target), 232);
    bus.an_pos = 8'd248; tick(); chk("t5_248", int'(bus.target), 248);
    bus.an_pos = 8'd250; tick(); chk("t5_250", int'(bus.target), 250);
    bus.an_pos = 8'd255; tick(); chk("t5_255", int'(bus.target), 255);
    repeat (5) tick();
    chk("t5_top_hold", int'(bus.target), 255);
    chk("t5_top_settling", int'(bus.settling), 0);
    bus.an_pos = 8'd0;
    tick();
    chk("t5_down_slew", int'(bus.settling), 1);
    chk("t5_down_target0", int'(bus.target), 255);
    for (int i = 0; i < 1020; i++) begin
      tick();
      chk("t5_down_target", int'(bus.target), 255 - (i + 1) / 4);
    end
    repeat (3) tick();
    chk("t5_bottom_settling", int'(bus.settling), 1);
    tick();
    chk("t5_bottom_track", int'(bus.settling), 0);
    repeat (5) tick();
    chk("t5_bottom_hold", int'(bus.target), 0);

    // Silent source after a direct move
    bus.an_pos = 8'd16;
    tick();
    chk("t6_direct", int'(bus.target), 16);
    idle_sources();
`ifdef SOURCE_TIMEOUT_EN
    repeat (19) tick();
    chk("t6_before_timeout", int'(bus.settling), 0);
    tick();
    chk("t6_timeout_slew", int'(bus.settling), 1);
    chk("t6_timeout_target", int'(bus.target), 16);
    wait_track("t6_park_wait", 600);
    chk("t6_parked", int'(bus.target), 128);
`else
    repeat (100) tick();
    chk("t6_silent_target", int'(bus.target), 16);
    chk("t6_silent_settling", int'(bus.settling), 0);
`endif

    // Back to mode 00: arm returns home
    bus.state = 2'd0;
    tick();
    chk("t7_src", int'(bus.src_active), 0);
    chk("t7_tvalid", int'(bus.target_valid), 0);
    wait_track("t7_home_wait", 700);
    chk("t7_home_target", int'(bus.target), 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
